muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences the shared multi-cycle multiplier and divider for the execute stage.
//  - Accepts one M-extension op at a time and latches its operands.
//  - Drives the mul or div unit and buffers its result until execute consumes it.
//  - Resolves RISC-V divide-by-zero and signed-overflow cases itself, without starting the divider.
//  - Aborts on pipeline flush and guards against a hung unit with a watchdog.
// PARAMETERS
//  TIMEOUT   128  max cycles in a WAIT state before abort (>=2)
//  CNT_W     8    watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk            in   1   clock
//  rst            in   1   asynchronous reset, active-high
//  req_valid      in   1   execute presents an op
//  req_ready      out  1   sequencer can accept (state==IDLE)
//  req_is_div     in   1   1=div/rem, 0=mul family
//  req_sign1      in   1   mul: src1 signed
//  req_sign2      in   1   mul: src2 signed
//  req_div_signed in   1   div/rem signed
//  req_word       in   1   *W op (32-bit operands in [31:0])
//  req_src1       in   64  operand 1
//  req_src2       in   64  operand 2
//  flush          in   1   kill in-flight op
//  resp_valid     out  1   result buffered (state==DONE)
//  resp_ready     in   1   execute consumes result
//  resp_hi        out  64  mul: high product; div: remainder
//  resp_lo        out  64  mul: low product; div: quotient
//  mul_start      out  1   level, held for all of MUL_WAIT
//  mul_kill       out  1   1-cycle abort pulse to multiplier
//  mul_ok         in   1   multiplier result valid
//  mul_hi         in   64  multiplier high result
//  mul_lo         in   64  multiplier low result
//  div_start      out  1   level, held for all of DIV_WAIT
//  div_kill       out  1   1-cycle abort pulse to divider
//  div_ready      in   1   divider result valid
//  div_quo        in   64  divider quotient
//  div_rem        in   64  divider remainder
//  op_src1        out  64  latched operand 1 to units
//  op_src2        out  64  latched operand 2 to units
//  op_sign1       out  1   latched sign control
//  op_sign2       out  1   latched sign control
//  timeout_err    out  1   sticky watchdog error
// BEHAVIOUR
//  Reset values: state=IDLE, all outputs 0, req_ready=1, timeout_err=0, counter=0.
//  States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
//  IDLE
//   - Accept on req_valid&req_ready&!flush; latch operands and controls.
//   - Div with divisor==0 (word: src2[31:0]==0):
//     lo = all-ones; hi = src1 (word: sext(src1[31:0])); go to DONE.
//   - Signed div with src1==min and src2==-1 (word: 32'h80000000 and 32'hffffffff):
//     lo = src1 (word: sext); hi = 0; go to DONE.
//   - Otherwise go to MUL_WAIT or DIV_WAIT.
//  Latency: accept in cycle N -> resp_valid in cycle N+1 for canned results.
//  MUL_WAIT / DIV_WAIT
//   - The matching start signal is high.
//   - On ok/ready, capture hi/lo into the buffer and go to DONE (resp_valid the next cycle).
//   - Unit results are passed through raw; execute applies W sign-extension.
//  DONE
//   - resp_valid=1; buffer stable.
//   - On resp_ready go to IDLE; a new op is accepted no earlier than the following cycle.
//  flush (any state)
//   - Go to IDLE next cycle and discard the buffer.
//   - If the state is a WAIT state, pulse mul_kill/div_kill for one cycle.
//   - flush beats a same-cycle mul_ok/div_ready and a same-cycle req_valid; neither is accepted.
//   - In DONE, flush drops resp_valid next cycle without needing resp_ready.
//  Watchdog
//   - Counter clears on entering a WAIT state and increments each cycle in it.
//   - When the counter reaches TIMEOUT-1 without ok/ready: pulse kill, go to IDLE, set timeout_err.
//   - timeout_err is sticky until rst; no response is produced for the aborted op.
//  Arithmetic and unit interface
//   - Overflow and zero checks use the latched operands only.
//   - ok/ready asserted outside the matching WAIT state is ignored.
//  Reset mid-op: async rst forces IDLE immediately; kills are not pulsed; units reset on the same rst.
// TESTING
//  mul src1=3 src2=-2, sign1=sign2=1; mul_ok after 5 cycles -> resp_lo=64'hFFFF_FFFF_FFFF_FFFA, resp_hi=all-ones.
//  divw src1=7 src2=0 -> no div_start; cycle after accept resp_lo=all-ones, resp_hi=7.
//  div src1=64'h8000_0000_0000_0000 src2=-1 signed -> resp_lo=src1, resp_hi=0, latency 1.
//  flush in cycle 3 of DIV_WAIT, div_ready same cycle -> div_kill 1 cycle, IDLE, no resp_valid.
//  div_ready never asserted, TIMEOUT=8 -> div_kill at 8th WAIT cycle, timeout_err=1 and stays.
//  DONE held 4 cycles with resp_ready=0 and req_valid=1 -> buffer stable, req_ready=0; then accept.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Execute-stage sequencer for the shared multi-cycle multiplier and divider.
// Latches one M-extension op, drives the selected unit and buffers the result until consumed.
module muldiv_sequencer #(
  parameter int unsigned TIMEOUT = 128,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_div,
  input  logic        req_sign1,
  input  logic        req_sign2,
  input  logic        req_div_signed,
  input  logic        req_word,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_hi,
  output logic [63:0] resp_lo,
  output logic        mul_start,
  output logic        mul_kill,
  input  logic        mul_ok,
  input  logic [63:0] mul_hi,
  input  logic [63:0] mul_lo,
  output logic        div_start,
  output logic        div_kill,
  input  logic        div_ready,
  input  logic [63:0] div_quo,
  input  logic [63:0] div_rem,
  output logic [63:0] op_src1,
  output logic [63:0] op_src2,
  output logic        op_sign1,
  output logic        op_sign2,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StMulWait, StDivWait, StDone} state_e;

  state_e             state_q, state_d;
  logic [63:0]        src1_q, src1_d, src2_q, src2_d;
  logic               sign1_q, sign1_d, sign2_q, sign2_d;
  logic [63:0]        buf_hi_q, buf_hi_d, buf_lo_q, buf_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [63:0] src1_ext;
  logic        div_zero;
  logic        div_ovf;
  logic        timeout_hit;

  // Canned results are decided from the operands being latched this cycle.
  assign src1_ext = req_word ? {{32{req_src1[31]}}, req_src1[31:0]} : req_src1;
  assign div_zero = req_word ? (req_src2[31:0] == 32'h0) : (req_src2 == 64'h0);
  assign div_ovf  = req_div_signed &
                    (req_word ? (req_src1[31:0] == 32'h8000_0000 &&
                                 req_src2[31:0] == 32'hffff_ffff)
                              : (req_src1 == {1'b1, 63'h0} && req_src2 == {64{1'b1}}));
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    buf_hi_d = buf_hi_q;
    buf_lo_d = buf_lo_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    mul_kill = 1'b0;
    div_kill = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid && !flush) begin
          src1_d  = req_src1;
          src2_d  = req_src2;
          sign1_d = req_is_div ? req_div_signed : req_sign1;
          sign2_d = req_is_div ? req_div_signed : req_sign2;
          cnt_d   = '0;
          if (req_is_div && div_zero) begin
            buf_lo_d = {64{1'b1}};
            buf_hi_d = src1_ext;
            state_d  = StDone;
          end else if (req_is_div && div_ovf) begin
            buf_lo_d = src1_ext;
            buf_hi_d = 64'h0;
            state_d  = StDone;
          end else begin
            state_d = req_is_div ? StDivWait : StMulWait;
          end
        end
      end
      StMulWait: begin
        if (flush) begin
          mul_kill = 1'b1;
          buf_hi_d = 64'h0;
          buf_lo_d = 64'h0;
          state_d  = StIdle;
        end else if (mul_ok) begin
          buf_hi_d = mul_hi;
          buf_lo_d = mul_lo;
          state_d  = StDone;
        end else if (timeout_hit) begin
          mul_kill = 1'b1;
          err_d    = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDivWait: begin
        if (flush) begin
          div_kill = 1'b1;
          buf_hi_d = 64'h0;
          buf_lo_d = 64'h0;
          state_d  = StIdle;
        end else if (div_ready) begin
          buf_hi_d = div_rem;
          buf_lo_d = div_quo;
          state_d  = StDone;
        end else if (timeout_hit) begin
          div_kill = 1'b1;
          err_d    = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        if (flush) begin
          buf_hi_d = 64'h0;
          buf_lo_d = 64'h0;
          state_d  = StIdle;
        end else if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      src1_q   <= 64'h0;
      src2_q   <= 64'h0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      buf_hi_q <= 64'h0;
      buf_lo_q <= 64'h0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      buf_hi_q <= buf_hi_d;
      buf_lo_q <= buf_lo_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign resp_valid  = (state_q == StDone);
  assign mul_start   = (state_q == StMulWait);
  assign div_start   = (state_q == StDivWait);
  assign resp_hi     = buf_hi_q;
  assign resp_lo     = buf_lo_q;
  assign op_src1     = src1_q;
  assign op_src2     = src2_q;
  assign op_sign1    = sign1_q;
  assign op_sign2    = sign2_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus flush, watchdog and hold sequences.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic        req_is_div = 1'b0, req_sign1 = 1'b0, req_sign2 = 1'b0;
  logic        req_div_signed = 1'b0, req_word = 1'b0;
  logic [63:0] req_src1 = 64'h0, req_src2 = 64'h0;
  logic        flush = 1'b0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [63:0] resp_hi, resp_lo;
  logic        mul_start, mul_kill, mul_ok = 1'b0;
  logic [63:0] mul_hi = 64'h0, mul_lo = 64'h0;
  logic        div_start, div_kill, div_ready = 1'b0;
  logic [63:0] div_quo = 64'h0, div_rem = 64'h0;
  logic [63:0] op_src1, op_src2;
  logic        op_sign1, op_sign2, timeout_err;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Min  = 64'h8000_0000_0000_0000;

  muldiv_sequencer #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_div(req_is_div),
    .req_sign1(req_sign1), .req_sign2(req_sign2), .req_div_signed(req_div_signed),
    .req_word(req_word), .req_src1(req_src1), .req_src2(req_src2),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hi(resp_hi), .resp_lo(resp_lo),
    .mul_start(mul_start), .mul_kill(mul_kill), .mul_ok(mul_ok),
    .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_start(div_start), .div_kill(div_kill), .div_ready(div_ready),
    .div_quo(div_quo), .div_rem(div_rem),
    .op_src1(op_src1), .op_src2(op_src2), .op_sign1(op_sign1), .op_sign2(op_sign2),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_div, s1, s2, ds, word, canned;
    int          lat;
    logic [63:0] a, b, uhi, ulo, ehi, elo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic is_div, input logic s1, input logic s2, input logic ds,
                           input logic word, input logic [63:0] a, input logic [63:0] b);
    req_is_div = is_div; req_sign1 = s1; req_sign2 = s2; req_div_signed = ds;
    req_word = word; req_src1 = a; req_src2 = b; req_valid = 1'b1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    drive_req(v.is_div, v.s1, v.s2, v.ds, v.word, v.a, v.b);
    #1;
    chk($sformatf("v%0d_req_ready", i), req_ready, 1);
    step();
    req_valid = 1'b0;
    chk($sformatf("v%0d_op_src1", i), op_src1, v.a);
    chk($sformatf("v%0d_op_src2", i), op_src2, v.b);
    chk($sformatf("v%0d_op_sign1", i), op_sign1, v.is_div ? v.ds : v.s1);
    if (v.canned) begin
      chk($sformatf("v%0d_resp_valid", i), resp_valid, 1);
      chk($sformatf("v%0d_no_start", i), {mul_start, div_start}, 0);
    end else begin
      for (int k = 0; k <= v.lat; k++) begin
        chk($sformatf("v%0d_wait_valid", i), resp_valid, 0);
        chk($sformatf("v%0d_start", i), {mul_start, div_start}, v.is_div ? 2'b01 : 2'b10);
        if (k < v.lat) step();
      end
      mul_hi = v.uhi; mul_lo = v.ulo; div_rem = v.uhi; div_quo = v.ulo;
      if (v.is_div) div_ready = 1'b1; else mul_ok = 1'b1;
      step();
      mul_ok = 1'b0; div_ready = 1'b0;
      chk($sformatf("v%0d_resp_valid", i), resp_valid, 1);
      chk($sformatf("v%0d_start_off", i), {mul_start, div_start}, 0);
    end
    chk($sformatf("v%0d_hi", i), resp_hi, v.ehi);
    chk($sformatf("v%0d_lo", i), resp_lo, v.elo);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk($sformatf("v%0d_idle", i), {req_ready, resp_valid}, 2'b10);
  endtask

  initial begin
    // is_div s1 s2 ds word canned lat  src1 src2  unit_hi unit_lo  exp_hi exp_lo
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE,
                Ones, 64'hFFFF_FFFF_FFFF_FFFA, Ones, 64'hFFFF_FFFF_FFFF_FFFA};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 64'd7, 64'd0,
                64'h0, 64'h0, 64'd7, Ones};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, Min, Ones,
                64'h0, 64'h0, 64'h0, Min};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 64'h0000_0000_8000_0000,
                64'h0000_0000_FFFF_FFFF, 64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_8000_0000};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, Min, Ones,
                Min, 64'h0, Min, 64'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 64'h1234, 64'h0,
                64'h0, 64'h0, 64'h1234, Ones};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 64'h5555_5555_9000_0001,
                64'h1_0000_0000, 64'h0, 64'h0, 64'hFFFF_FFFF_9000_0001, Ones};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 64'h3_0000_0000, 64'h1_0000_0000,
                64'h0, 64'd3, 64'h0, 64'd3};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, Ones, 64'd2,
                64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, Min, 64'd1,
                64'h0, Min, 64'h0, Min};

    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outputs", {resp_valid, mul_start, div_start, mul_kill, div_kill, timeout_err}, 0);
    chk("rst_resp_lo", resp_lo, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) run_vec(i);

    // Unit handshakes outside a wait state must be ignored.
    mul_ok = 1'b1; div_ready = 1'b1;
    step();
    mul_ok = 1'b0; div_ready = 1'b0;
    chk("stray_ok_ignored", {req_ready, resp_valid}, 2'b10);

    // flush beats a same-cycle request.
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd4, 64'd5);
    flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", {req_ready, mul_start}, 2'b10);

    // flush in cycle 3 of a divide, racing div_ready.
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    step();
    req_valid = 1'b0;
    step();
    step();
    flush = 1'b1; div_ready = 1'b1; div_quo = 64'd14; div_rem = 64'd2;
    #1;
    chk("div_flush_kill", {div_kill, mul_kill}, 2'b10);
    step();
    flush = 1'b0; div_ready = 1'b0;
    #1;
    chk("div_flush_kill_pulse", div_kill, 0);
    chk("div_flush_idle", {req_ready, resp_valid}, 2'b10);
    step();
    chk("div_flush_no_resp", resp_valid, 0);

    // flush during a multiply.
    drive_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd9, 64'd9);
    step();
    req_valid = 1'b0;
    step();
    flush = 1'b1;
    #1;
    chk("mul_flush_kill", {mul_kill, div_kill}, 2'b10);
    step();
    flush = 1'b0;
    #1;
    chk("mul_flush_after", {mul_kill, req_ready, resp_valid}, 3'b010);

    // flush in DONE drops the response without resp_ready.
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd11, 64'd0);
    step();
    req_valid = 1'b0;
    chk("done_flush_pre", resp_valid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("done_flush_post", {req_ready, resp_valid}, 2'b10);
    chk("timeout_err_clear", timeout_err, 0);

    // Watchdog: divider never answers.
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("wd_kill_c%0d", c), div_kill, (c == 8) ? 1 : 0);
      if (c < 8) chk($sformatf("wd_start_c%0d", c), div_start, 1);
      if (c < 8) step();
    end
    step();
    chk("wd_err_set", timeout_err, 1);
    chk("wd_idle", {req_ready, resp_valid, div_start}, 3'b100);

    // Hold DONE for 4 cycles while a new request waits.
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd7, 64'd0);
    step();
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd3, 64'd5);
    for (int h = 0; h < 4; h++) begin
      chk($sformatf("hold%0d_flags", h), {resp_valid, req_ready}, 2'b10);
      chk($sformatf("hold%0d_lo", h), resp_lo, Ones);
      chk($sformatf("hold%0d_hi", h), resp_hi, 64'd7);
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("hold_release_idle", {req_ready, resp_valid, mul_start}, 3'b100);
    step();
    req_valid = 1'b0;
    chk("hold_next_accept", mul_start, 1);
    chk("hold_next_src1", op_src1, 64'd3);
    mul_ok = 1'b1; mul_hi = 64'h0; mul_lo = 64'd15;
    step();
    mul_ok = 1'b0;
    chk("hold_next_lo", resp_lo, 64'd15);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("wd_err_sticky", timeout_err, 1);

    // Asynchronous reset mid-operation.
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd6, 64'd7);
    step();
    req_valid = 1'b0;
    chk("arst_pre_start", mul_start, 1);
    rst = 1'b1;
    #1;
    chk("arst_state", {req_ready, mul_start, mul_kill, resp_valid, timeout_err}, 5'b10000);
    chk("arst_src1", op_src1, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
